// File: rtl/cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// cpu_run_monitor
// Run controller and monitor for the pipelined CPU. On a start request it
// holds the CPU in reset for RST_CYCLES edges, then lets it run. While it
// runs, the block counts cycles, retired instructions and taken branches.
// It stops the run on end-of-program, on a self-loop halt or on a timeout.
// After that the CPU is frozen in reset and the counters are held for
// readout.
//
// Ports
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-high reset
//   start         in   one-cycle run request (sampled in IDLE / DONE only)
//   pc            in   current fetch PC from the CPU
//   retire_valid  in   one instruction retired this cycle
//   branch_taken  in   a branch/jump redirected fetch this cycle
//   cpu_rst       out  active-high reset to the CPU
//   running       out  high while in RUN
//   done          out  high while in DONE
//   status        out  00 none, 01 end-of-program, 10 self-loop, 11 timeout
//   cycle_count   out  RUN cycles elapsed
//   retire_count  out  retired instructions
//   branch_count  out  taken branches
//   last_pc       out  PC registered on the previous RUN cycle
// ---------------------------------------------------------------------------
module cpu_run_monitor #(
    parameter int unsigned           ADDR_W          = 32,
    parameter logic [ADDR_W-1:0]     MAX_INSTR_ADDR  = ADDR_W'(32'h90),
    parameter int unsigned           RST_CYCLES      = 2,
    parameter int unsigned           SELF_LOOP_LIMIT = 8,
    parameter int unsigned           TIMEOUT         = 4096,
    parameter int unsigned           CNT_W           = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    input  logic              retire_valid,
    input  logic              branch_taken,
    output logic              cpu_rst,
    output logic              running,
    output logic              done,
    output logic [1:0]        status,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  retire_count,
    output logic [CNT_W-1:0]  branch_count,
    output logic [ADDR_W-1:0] last_pc
);

    localparam int unsigned RST_CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned LOOP_W    = $clog2(SELF_LOOP_LIMIT + 1);

    localparam logic [RST_CNT_W-1:0] RST_LAST   = RST_CNT_W'(RST_CYCLES - 1);
    localparam logic [LOOP_W-1:0]    LOOP_LIMIT = LOOP_W'(SELF_LOOP_LIMIT);
    localparam logic [CNT_W-1:0]     TIMEOUT_C  = CNT_W'(TIMEOUT);

    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_EOP  = 2'b01;
    localparam logic [1:0] ST_LOOP = 2'b10;
    localparam logic [1:0] ST_TMO  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RESET = 2'b01,
        S_RUN   = 2'b10,
        S_DONE  = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic [RST_CNT_W-1:0] rst_cnt_q,  rst_cnt_d;
    logic [LOOP_W-1:0]    loop_cnt_q, loop_cnt_d;
    logic                 pc_valid_q, pc_valid_d;
    logic [CNT_W-1:0]     cycle_q,    cycle_d;
    logic [CNT_W-1:0]     retire_q,   retire_d;
    logic [CNT_W-1:0]     branch_q,   branch_d;
    logic [ADDR_W-1:0]    last_pc_q,  last_pc_d;
    logic [1:0]           status_q,   status_d;
    logic                 cpu_rst_q,  cpu_rst_d;
    logic                 running_q,  running_d;
    logic                 done_q,     done_d;

    // Termination evaluation on this cycle's inputs
    logic [CNT_W-1:0]  cycle_inc;
    logic [LOOP_W-1:0] loop_inc;
    logic              hit_eop;
    logic              hit_loop;
    logic              hit_tmo;
    logic              term;
    logic [1:0]        cause;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Next counter values and stop conditions, as if this were a RUN cycle
    always_comb begin
        cycle_inc = sat_inc(cycle_q);
        loop_inc  = '0;
        if (pc_valid_q && (pc == last_pc_q)) begin
            loop_inc = (&loop_cnt_q) ? loop_cnt_q : loop_cnt_q + LOOP_W'(1);
        end
        hit_eop  = (pc >= MAX_INSTR_ADDR);
        hit_loop = (loop_inc == LOOP_LIMIT);
        hit_tmo  = (cycle_inc == TIMEOUT_C);
        term     = hit_eop | hit_loop | hit_tmo;
        if (hit_eop) begin
            cause = ST_EOP;
        end else if (hit_loop) begin
            cause = ST_LOOP;
        end else if (hit_tmo) begin
            cause = ST_TMO;
        end else begin
            cause = ST_NONE;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RESET;
            S_RESET: if (rst_cnt_q == RST_LAST) state_d = S_RUN;
            S_RUN:   if (term) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RESET;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        rst_cnt_d  = '0;
        loop_cnt_d = loop_cnt_q;
        pc_valid_d = pc_valid_q;
        cycle_d    = cycle_q;
        retire_d   = retire_q;
        branch_d   = branch_q;
        last_pc_d  = last_pc_q;
        status_d   = status_q;
        // Control outputs follow the state being entered so they are registered
        cpu_rst_d  = (state_d != S_RUN);
        running_d  = (state_d == S_RUN);
        done_d     = (state_d == S_DONE);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    loop_cnt_d = '0;
                    pc_valid_d = 1'b0;
                    cycle_d    = '0;
                    retire_d   = '0;
                    branch_d   = '0;
                    status_d   = ST_NONE;
                end
            end
            S_RESET: begin
                if (rst_cnt_q != RST_LAST) begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end
            S_RUN: begin
                cycle_d    = cycle_inc;
                retire_d   = retire_valid ? sat_inc(retire_q) : retire_q;
                branch_d   = branch_taken ? sat_inc(branch_q) : branch_q;
                last_pc_d  = pc;
                pc_valid_d = 1'b1;
                loop_cnt_d = loop_inc;
                if (term) begin
                    status_d = cause;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt_q  <= '0;
            loop_cnt_q <= '0;
            pc_valid_q <= 1'b0;
            cycle_q    <= '0;
            retire_q   <= '0;
            branch_q   <= '0;
            last_pc_q  <= '0;
            status_q   <= ST_NONE;
            cpu_rst_q  <= 1'b1;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rst_cnt_q  <= rst_cnt_d;
            loop_cnt_q <= loop_cnt_d;
            pc_valid_q <= pc_valid_d;
            cycle_q    <= cycle_d;
            retire_q   <= retire_d;
            branch_q   <= branch_d;
            last_pc_q  <= last_pc_d;
            status_q   <= status_d;
            cpu_rst_q  <= cpu_rst_d;
            running_q  <= running_d;
            done_q     <= done_d;
        end
    end

    assign cpu_rst      = cpu_rst_q;
    assign running      = running_q;
    assign done         = done_q;
    assign status       = status_q;
    assign cycle_count  = cycle_q;
    assign retire_count = retire_q;
    assign branch_count = branch_q;
    assign last_pc      = last_pc_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_monitor
// Directed bench for cpu_run_monitor with TIMEOUT=64. A table of run
// scenarios (PC pattern, retire/branch masks, expected final counters) is
// applied in a loop. Hand-written sequences cover the reset pulse timing,
// a start ignored while running, and an async reset in the middle of a run.
// ---------------------------------------------------------------------------
module tb_cpu_run_monitor;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic        retire_valid;
    logic        branch_taken;
    logic        cpu_rst;
    logic        running;
    logic        done;
    logic [1:0]  status;
    logic [31:0] cycle_count;
    logic [31:0] retire_count;
    logic [31:0] branch_count;
    logic [31:0] last_pc;

    int n_checks = 0;
    int n_fail   = 0;

    cpu_run_monitor #(
        .ADDR_W          (32),
        .MAX_INSTR_ADDR  (32'h90),
        .RST_CYCLES      (2),
        .SELF_LOOP_LIMIT (8),
        .TIMEOUT         (64),
        .CNT_W           (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pc           (pc),
        .retire_valid (retire_valid),
        .branch_taken (branch_taken),
        .cpu_rst      (cpu_rst),
        .running      (running),
        .done         (done),
        .status       (status),
        .cycle_count  (cycle_count),
        .retire_count (retire_count),
        .branch_count (branch_count),
        .last_pc      (last_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          mode;
        logic [63:0] ret_mask;
        logic [63:0] br_mask;
        logic [1:0]  exp_status;
        int          exp_cyc;
        int          exp_ret;
        int          exp_br;
        logic [31:0] exp_last;
    } row_t;

    row_t rows[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // PC seen on RUN cycle k (0-based) for each scenario pattern
    function automatic logic [31:0] pc_of(input int mode, input int k);
        logic [31:0] alt;
        alt = (k % 2 == 0) ? 32'h10 : 32'h14;
        case (mode)
            0:       return 32'(4 * k);
            1:       return (k < 16) ? 32'(4 * k) : 32'h40;
            2:       return alt;
            3:       return (k < 13) ? 32'(4 * k) : 32'h90;
            4:       return (k < 63) ? alt : 32'h90;
            5:       return (k < 55) ? alt : 32'h20;
            6:       return (k < 5) ? 32'(4 * k) : 32'hFFFF_FFF0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input row_t r, input int k);
        pc           = pc_of(r.mode, k);
        retire_valid = (k < 64) ? r.ret_mask[k] : 1'b0;
        branch_taken = (k < 64) ? r.br_mask[k]  : 1'b0;
    endtask

    // One full run from IDLE or DONE through to DONE
    task automatic run_row(input row_t r);
        int k;
        int w;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!running && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk({r.name, ":enter_run"}, 64'(running), 64'd1);
        chk({r.name, ":cyc_at_entry"}, 64'(cycle_count), 64'd0);
        chk({r.name, ":status_cleared"}, 64'(status), 64'd0);
        k = 0;
        while (!done && k < 100) begin
            drive(r, k);
            @(negedge clk);
            k++;
        end
        chk({r.name, ":done"}, 64'(done), 64'd1);
        chk({r.name, ":run_len"}, 64'(k), 64'(r.exp_cyc));
        chk({r.name, ":status"}, 64'(status), 64'(r.exp_status));
        chk({r.name, ":cycle_count"}, 64'(cycle_count), 64'(r.exp_cyc));
        chk({r.name, ":retire_count"}, 64'(retire_count), 64'(r.exp_ret));
        chk({r.name, ":branch_count"}, 64'(branch_count), 64'(r.exp_br));
        chk({r.name, ":last_pc"}, 64'(last_pc), 64'(r.exp_last));
        chk({r.name, ":cpu_rst"}, 64'(cpu_rst), 64'd1);
        chk({r.name, ":running"}, 64'(running), 64'd0);
        // DONE holds everything regardless of CPU activity
        pc           = 32'h0;
        retire_valid = 1'b1;
        branch_taken = 1'b1;
        @(negedge clk);
        chk({r.name, ":hold_cycles"}, 64'(cycle_count), 64'(r.exp_cyc));
        chk({r.name, ":hold_retire"}, 64'(retire_count), 64'(r.exp_ret));
        chk({r.name, ":hold_done"}, 64'(done), 64'd1);
        retire_valid = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        rows[0] = '{"eop",        0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                    2'b01, 37, 37, 0, 32'h90};
        rows[1] = '{"self_loop",  1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                    2'b10, 25, 25, 0, 32'h40};
        rows[2] = '{"timeout",    2, 64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA,
                    2'b11, 64, 32, 32, 32'h14};
        rows[3] = '{"branches",   3, 64'h3FF, 64'h1C88,
                    2'b01, 14, 10, 5, 32'h90};
        rows[4] = '{"eop_vs_tmo", 4, 64'h0, 64'h0,
                    2'b01, 64, 0, 0, 32'h90};
        rows[5] = '{"loop_vs_tmo", 5, 64'h0, 64'h0,
                    2'b10, 64, 0, 0, 32'h20};
        rows[6] = '{"eop_high_pc", 6, 64'h1F, 64'h20,
                    2'b01, 6, 5, 1, 32'hFFFF_FFF0};

        rst          = 1'b1;
        start        = 1'b0;
        pc           = 32'h0;
        retire_valid = 1'b0;
        branch_taken = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst:cpu_rst", 64'(cpu_rst), 64'd1);
        chk("rst:running", 64'(running), 64'd0);
        chk("rst:done", 64'(done), 64'd0);
        chk("rst:status", 64'(status), 64'd0);
        chk("rst:cycle_count", 64'(cycle_count), 64'd0);
        chk("rst:last_pc", 64'(last_pc), 64'd0);

        // Reset pulse: start sampled at E0, cpu_rst held through E1/E2
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pulse:e0_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("pulse:e0_running", 64'(running), 64'd0);
        @(negedge clk);
        chk("pulse:e1_cpu_rst", 64'(cpu_rst), 64'd1);
        chk("pulse:e1_running", 64'(running), 64'd0);
        drive(rows[0], 0);
        @(negedge clk);
        chk("pulse:e2_cpu_rst", 64'(cpu_rst), 64'd0);
        chk("pulse:e2_running", 64'(running), 64'd1);
        chk("pulse:e2_cycle_count", 64'(cycle_count), 64'd0);

        // Run 10 EOP-pattern cycles with a start pulse that must be ignored
        for (int k = 0; k < 10; k++) begin
            drive(rows[0], k);
            start = (k == 5);
            @(negedge clk);
        end
        start = 1'b0;
        chk("mid:cycle_count", 64'(cycle_count), 64'd10);
        chk("mid:retire_count", 64'(retire_count), 64'd10);
        chk("mid:last_pc", 64'(last_pc), 64'h24);
        chk("mid:running", 64'(running), 64'd1);

        // Async reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("async:cpu_rst", 64'(cpu_rst), 64'd1);
        chk("async:running", 64'(running), 64'd0);
        chk("async:status", 64'(status), 64'd0);
        chk("async:cycle_count", 64'(cycle_count), 64'd0);
        chk("async:retire_count", 64'(retire_count), 64'd0);
        chk("async:last_pc", 64'(last_pc), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Scenario table; first row re-runs EOP after the async reset
        for (int i = 0; i < 7; i++) begin
            run_row(rows[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
